// File: rtl/regbank_pkg.sv
// Shared definitions for the regbank_rw register bank.
//   DefNregs / DefWidth : default register count and width.
//   strb_merge          : byte-lane merge; selects the new lane when its strobe is set.
package regbank_pkg;

  localparam int unsigned DefNregs = 4;
  localparam int unsigned DefWidth = 32;

  function automatic logic [7:0] strb_merge(input logic [7:0] old_lane,
                                            input logic [7:0] new_lane,
                                            input logic       strb);
    return strb ? new_lane : old_lane;
  endfunction

endpackage

// File: rtl/reg_en_strb.sv
// One WIDTH-bit storage register with byte-lane strobed write enable.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, loads RST_VAL
//   clr  : synchronous clear, loads RST_VAL, has priority over en
//   en   : write enable
//   strb : byte-lane mask, bit i covers d[8i+7:8i]
//   d    : write data
//   q    : current register value
module reg_en_strb
  import regbank_pkg::*;
#(
  parameter int unsigned      WIDTH   = DefWidth,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [WIDTH/8-1:0] strb,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RST_VAL;
    end else if (en) begin
      for (int b = 0; b < int'(WIDTH / 8); b++) begin
        q_d[8*b +: 8] = strb_merge(q_q[8*b +: 8], d[8*b +: 8], strb[b]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/regbank_rw.sv
// Bank of NREGS strobed registers with an indexed write port and a registered read port.
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   clr               : synchronous clear of every register to RST_VAL; drops a same-cycle write
//   wr_en/idx/strb/data : write request, index, byte strobes, data
//   rd_en/idx         : read request and index
//   rd_data           : read data, valid with rd_valid, holds when no read is issued
//   rd_valid          : pulses the cycle after rd_en
//   rd_err            : with rd_valid, the read index was out of range
//   wr_err            : pulses the cycle after an out-of-range write
module regbank_rw
  import regbank_pkg::*;
#(
  parameter int unsigned      NREGS   = DefNregs,
  parameter int unsigned      WIDTH   = DefWidth,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      BYPASS  = 1,
  parameter int unsigned      IDX_W   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [WIDTH/8-1:0] wr_strb,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output logic               wr_err
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_in_range, rd_in_range;
  logic [WIDTH-1:0] rd_old, rd_fwd;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_err_q, wr_err_q;

  assign wr_in_range = 32'(wr_idx) < NREGS;
  assign rd_in_range = 32'(rd_idx) < NREGS;

  for (genvar i = 0; i < int'(NREGS); i++) begin : g_reg
    logic en;
    assign en = wr_en & (wr_idx == IDX_W'(i)) & ~clr;

    reg_en_strb #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .strb(wr_strb),
      .d   (wr_data),
      .q   (regs[i])
    );
  end

  // Compare against every index instead of indexing the array, so an
  // out-of-range index never addresses storage and simply yields zero.
  always_comb begin
    rd_old = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_old = regs[i];
      end
    end
  end

  // Forward a same-cycle write; clr drops the write, so the read keeps the pre-clear value.
  always_comb begin
    rd_fwd = rd_old;
    if ((BYPASS != 0) && wr_en && !clr && wr_in_range && (wr_idx == rd_idx)) begin
      for (int b = 0; b < int'(WIDTH / 8); b++) begin
        rd_fwd[8*b +: 8] = strb_merge(rd_old[8*b +: 8], wr_data[8*b +: 8], wr_strb[b]);
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_in_range ? rd_fwd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en & ~rd_in_range;
      wr_err_q   <= wr_en & ~wr_in_range & ~clr;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_regbank_rw.sv
module tb_regbank_rw;

  localparam logic [31:0] RstVal = 32'hC0DE_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 4-entry bypass and non-bypass instances.
  logic        rst, clr, wr_en, rd_en;
  logic [1:0]  wr_idx, rd_idx;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;

  logic [31:0] rd_data, nb_rd_data;
  logic        rd_valid, rd_err, wr_err;
  logic        nb_rd_valid, nb_rd_err, nb_wr_err;

  // Stimulus for the 5-entry instance.
  logic        r5_clr, r5_wr_en, r5_rd_en;
  logic [2:0]  r5_wr_idx, r5_rd_idx;
  logic [3:0]  r5_wr_strb;
  logic [31:0] r5_wr_data, r5_rd_data;
  logic        r5_rd_valid, r5_rd_err, r5_wr_err;

  regbank_rw #(.NREGS(4), .WIDTH(32), .RST_VAL(RstVal), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_strb(wr_strb), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .wr_err(wr_err)
  );

  regbank_rw #(.NREGS(4), .WIDTH(32), .RST_VAL(RstVal), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_strb(wr_strb), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_data(nb_rd_data), .rd_valid(nb_rd_valid), .rd_err(nb_rd_err), .wr_err(nb_wr_err)
  );

  regbank_rw #(.NREGS(5), .WIDTH(32), .RST_VAL(RstVal), .BYPASS(1)) dut_r5 (
    .clk(clk), .rst(rst), .clr(r5_clr),
    .wr_en(r5_wr_en), .wr_idx(r5_wr_idx), .wr_strb(r5_wr_strb), .wr_data(r5_wr_data),
    .rd_en(r5_rd_en), .rd_idx(r5_rd_idx),
    .rd_data(r5_rd_data), .rd_valid(r5_rd_valid), .rd_err(r5_rd_err), .wr_err(r5_wr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        err;
    logic        wr_err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model [4];
  logic [31:0] hold;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Drive one cycle on the 4-entry instances and queue the expected output state.
  task automatic cycle(input logic r, input logic c, input logic we, input logic [1:0] wi,
                       input logic [3:0] ws, input logic [31:0] wd, input logic re,
                       input logic [1:0] ri);
    exp_t e;
    rst = r; clr = c; wr_en = we; wr_idx = wi; wr_strb = ws; wr_data = wd;
    rd_en = re; rd_idx = ri;
    e.err = 1'b0;
    e.wr_err = 1'b0;
    if (r) begin
      e.valid = 1'b0;
      hold = '0;
      for (int i = 0; i < 4; i++) model[i] = RstVal;
    end else begin
      e.valid = re;
      if (re) begin
        hold = model[ri];
        if (we && !c && wi == ri) hold = merge(model[ri], wd, ws);
      end
      if (c) begin
        for (int i = 0; i < 4; i++) model[i] = RstVal;
      end else if (we) begin
        model[wi] = merge(model[wi], wd, ws);
      end
    end
    e.data = hold;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (rd_valid !== mon_e.valid)
        $display("FAIL sb_rd_valid: got %b want %b", rd_valid, mon_e.valid);
      else n_pass++;
      n_checks++;
      if (rd_data !== mon_e.data)
        $display("FAIL sb_rd_data: got %h want %h", rd_data, mon_e.data);
      else n_pass++;
      if (mon_e.valid) begin
        n_checks++;
        if (rd_err !== mon_e.err) $display("FAIL sb_rd_err: got %b want %b", rd_err, mon_e.err);
        else n_pass++;
      end
      n_checks++;
      if (wr_err !== mon_e.wr_err) $display("FAIL sb_wr_err: got %b want %b", wr_err, mon_e.wr_err);
      else n_pass++;
    end
  end

  task automatic test_reset();
    // rst must win over a concurrent write and read.
    cycle(1, 0, 1, 2'd0, 4'hF, 32'hFFFF_FFFF, 1, 2'd0);
    cycle(1, 0, 1, 2'd0, 4'hF, 32'hFFFF_FFFF, 1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'(i));
      n_checks++;
      if (rd_data !== RstVal) $display("FAIL reset_read: idx %0d got %h want %h", i, rd_data, RstVal);
      else n_pass++;
      cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 0, 2'd0);
    end
  endtask

  task automatic test_strobe();
    cycle(0, 0, 1, 2'd2, 4'hF, 32'h0, 0, 2'd0);
    cycle(0, 0, 1, 2'd2, 4'b0101, 32'hAABB_CCDD, 0, 2'd0);
    cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'd2);
    n_checks++;
    if (rd_data !== 32'h00BB_00DD) $display("FAIL strobe_write: got %h want 00bb00dd", rd_data);
    else n_pass++;
    // strb=0 write is a no-op.
    cycle(0, 0, 1, 2'd2, 4'h0, 32'hFFFF_FFFF, 0, 2'd0);
    cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'd2);
    n_checks++;
    if (rd_data !== 32'h00BB_00DD) $display("FAIL strobe_zero: got %h want 00bb00dd", rd_data);
    else n_pass++;
  endtask

  task automatic test_bypass();
    cycle(0, 0, 1, 2'd1, 4'hF, 32'h1111_1111, 0, 2'd0);
    cycle(0, 0, 1, 2'd1, 4'hF, 32'h2222_2222, 1, 2'd1);
    n_checks++;
    if (rd_data !== 32'h2222_2222) $display("FAIL bypass_on: got %h want 22222222", rd_data);
    else n_pass++;
    n_checks++;
    if (nb_rd_valid !== 1'b1 || nb_rd_data !== 32'h1111_1111)
      $display("FAIL bypass_off: got v=%b %h want v=1 11111111", nb_rd_valid, nb_rd_data);
    else n_pass++;
    cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'd1);
    n_checks++;
    if (nb_rd_data !== 32'h2222_2222) $display("FAIL bypass_off_next: got %h want 22222222", nb_rd_data);
    else n_pass++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 2'(i), 4'hF, 32'h1010_1010 * (i + 1), 0, 2'd0);
    // Same-cycle read sees the pre-clear value; the write is dropped.
    cycle(0, 1, 1, 2'd0, 4'hF, 32'hDEAD_BEEF, 1, 2'd3);
    n_checks++;
    if (rd_data !== 32'h4040_4040) $display("FAIL clear_read_old: got %h want 40404040", rd_data);
    else n_pass++;
    n_checks++;
    if (wr_err !== 1'b0) $display("FAIL clear_wr_err: got %b want 0", wr_err);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'(i));
      n_checks++;
      if (rd_data !== RstVal) $display("FAIL clear_value: idx %0d got %h want %h", i, rd_data, RstVal);
      else n_pass++;
    end
  endtask

  task automatic r5_step(input logic c, input logic we, input logic [2:0] wi, input logic [31:0] wd,
                         input logic re, input logic [2:0] ri);
    r5_clr = c; r5_wr_en = we; r5_wr_idx = wi; r5_wr_strb = 4'hF; r5_wr_data = wd;
    r5_rd_en = re; r5_rd_idx = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic test_range();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    r5_step(0, 1, 3'd4, 32'hCAFE_F00D, 0, 3'd0);
    n_checks++;
    if (r5_wr_err !== 1'b0) $display("FAIL range_wr_ok: got %b want 0", r5_wr_err);
    else n_pass++;
    r5_step(0, 1, 3'd7, 32'hFFFF_FFFF, 0, 3'd0);
    n_checks++;
    if (r5_wr_err !== 1'b1) $display("FAIL range_wr_err: got %b want 1", r5_wr_err);
    else n_pass++;
    r5_step(0, 0, 3'd0, 32'h0, 1, 3'd6);
    n_checks++;
    if (r5_wr_err !== 1'b0) $display("FAIL range_wr_pulse: got %b want 0", r5_wr_err);
    else n_pass++;
    n_checks++;
    if (r5_rd_valid !== 1'b1 || r5_rd_err !== 1'b1 || r5_rd_data !== 32'h0)
      $display("FAIL range_rd: got v=%b e=%b %h want v=1 e=1 0", r5_rd_valid, r5_rd_err, r5_rd_data);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      r5_step(0, 0, 3'd0, 32'h0, 1, 3'(i));
      n_checks++;
      if (r5_rd_err !== 1'b0 || r5_rd_data !== ((i == 4) ? 32'hCAFE_F00D : RstVal))
        $display("FAIL range_no_change: idx %0d got e=%b %h", i, r5_rd_err, r5_rd_data);
      else n_pass++;
    end
    r5_step(1, 1, 3'd7, 32'h0, 0, 3'd0);
    n_checks++;
    if (r5_wr_err !== 1'b0) $display("FAIL range_clr_wr_err: got %b want 0", r5_wr_err);
    else n_pass++;
    r5_step(0, 0, 3'd0, 32'h0, 0, 3'd0);
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 2'((i + 1) % 4), 4'hF, $urandom, 1, 2'(i % 4));
      if (rd_valid === 1'b1) n_valid++;
    end
    n_checks++;
    if (n_valid != 8) $display("FAIL stream_valid_count: got %0d want 8", n_valid);
    else n_pass++;
    cycle(1, 0, 1, 2'd0, 4'hF, 32'h0, 1, 2'd1);
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL stream_rst_kill: got %b want 0", rd_valid);
    else n_pass++;
    cycle(0, 0, 0, 2'd0, 4'h0, 32'h0, 1, 2'd0);
  endtask

  initial begin
    r5_clr = 1'b0; r5_wr_en = 1'b0; r5_wr_idx = '0; r5_wr_strb = '0; r5_wr_data = '0;
    r5_rd_en = 1'b0; r5_rd_idx = '0;
    test_reset();
    test_strobe();
    test_bypass();
    test_clear();
    test_range();
    test_back_to_back();
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
